// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter one byte at a time over its DV/Done handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  reset,
  input  logic                  i_Wr,
  input  logic [7:0]            i_Data,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Busy,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Done
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic                  i_Ovf_Clr,
  output logic                  o_Ovf
`endif
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_WAIT_CLR  = 2'd2
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  logic             wr_en;
  logic             pop;

  // A full FIFO drops the write even when a pop frees a slot in the same cycle.
  assign wr_en   = i_Wr & ~o_Full;
  assign pop     = (state == S_WAIT_DONE) & i_Tx_Done;
  assign o_Full  = (o_Count == CNT_W'(DEPTH));
  assign o_Empty = (o_Count == '0);
  assign o_Busy  = ~o_Empty | (state != S_IDLE);

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr] <= i_Data;
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   o_Count <= o_Count + CNT_W'(1);
        2'b01:   o_Count <= o_Count - CNT_W'(1);
        default: o_Count <= o_Count;
      endcase
    end
  end

  // Handshake sequencer; WAIT_CLR keeps the next DV off until the transmitter drops Done.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state     <= S_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (!o_Empty) begin
            o_Tx_Byte <= mem[rd_ptr];
            o_Tx_DV   <= 1'b1;
            state     <= S_WAIT_DONE;
          end else begin
            o_Tx_DV <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            o_Tx_DV <= 1'b0;
            state   <= S_WAIT_CLR;
          end
        end
        S_WAIT_CLR: begin
          o_Tx_DV <= 1'b0;
          if (!i_Tx_Done) state <= S_IDLE;
        end
        default: begin
          o_Tx_DV <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky overflow; a dropped write wins over a clear in the same cycle.
  always_ff @(posedge i_Clock) begin
    if (reset)                o_Ovf <= 1'b0;
    else if (i_Wr && o_Full)  o_Ovf <= 1'b1;
    else if (i_Ovf_Clr)       o_Ovf <= 1'b0;
  end
`endif

endmodule
